// File: rtl/pio_cmd_pkg.sv
// Shared types and status-word layout for the PIO command issuer.
// Command entries and FSM states used by the issuer and its buffer.
package pio_cmd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        GAP,
        WAIT,
        ERROR
    } state_e;

    typedef struct packed {
        logic        is_wait;
        logic [31:0] data;
    } cmd_entry_t;

    localparam int MOVE_DONE_BIT  = 31;
    localparam int LDST_DONE_BIT  = 30;
    localparam int CU_DONE_BIT    = 29;
    localparam int FETCH_DONE_BIT = 28;
    localparam int EXEC_DONE_LSB  = 0;
    localparam int EXEC_DONE_W    = 28;

    function automatic logic mask_met(
        input logic [31:0] status,
        input logic [31:0] mask
    );
        return (status & mask) == mask;
    endfunction

endpackage

// File: rtl/pio_cmd_fifo.sv
// Command entry buffer for the PIO issuer.
// Head entry is presented combinationally; push and pop may coincide.
module pio_cmd_fifo
    import pio_cmd_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  cmd_entry_t wr_entry,
    input  logic       pop,
    output cmd_entry_t rd_entry,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    cmd_entry_t mem [0:DEPTH-1];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_entry = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)
                rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // When full, a same-cycle pop has already read this slot.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= wr_entry;
    end

endmodule

// File: rtl/pio_cmd_issuer.sv
// On-fabric initiator for the 32-bit PIO command channel.
// Runs a buffered list of issue/wait entries against the control unit.
module pio_cmd_issuer
    import pio_cmd_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int GAP_CYC    = 2,
    parameter int TIMEOUT_W  = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_wait,
    input  logic [31:0] cmd_data,
    output logic [31:0] h2f_pio32,
    output logic        h2f_write,
    input  logic [31:0] f2h_pio32,
    output logic        busy,
    output logic        err_timeout,
    input  logic        err_clear,
    output logic [15:0] issued_cnt
);

    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);
    localparam logic [TIMEOUT_W-1:0] TMO_LAST = ~TIMEOUT_W'(1);

    state_e               state;
    cmd_entry_t           wr_entry;
    cmd_entry_t           head;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;
    logic                 rst_done;
    logic                 wait_hit;
    logic [31:0]          sticky;
    logic [31:0]          mask;
    logic [TIMEOUT_W-1:0] tmo_cnt;
    logic [GW-1:0]        gap_cnt;

    assign pop       = (state == IDLE) && !empty;
    assign cmd_ready = rst_done && (!full || pop);
    assign push      = cmd_valid && cmd_ready;
    assign busy      = (state != IDLE) || !empty;
    assign wait_hit  = mask_met(sticky | f2h_pio32, mask);

    assign wr_entry.is_wait = cmd_wait;
    assign wr_entry.data    = cmd_data;

    pio_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .wr_entry (wr_entry),
        .pop      (pop),
        .rd_entry (head),
        .full     (full),
        .empty    (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rst_done    <= 1'b0;
            h2f_pio32   <= '0;
            h2f_write   <= 1'b0;
            issued_cnt  <= '0;
            err_timeout <= 1'b0;
            sticky      <= '0;
            mask        <= '0;
            tmo_cnt     <= '0;
            gap_cnt     <= '0;
        end else begin
            rst_done  <= 1'b1;
            h2f_write <= 1'b0;
            // Status seen during the write cycle predates the command.
            sticky    <= (state == ISSUE) ? '0 : (sticky | f2h_pio32);
            if (err_clear)
                err_timeout <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pop) begin
                        if (head.is_wait) begin
                            mask    <= head.data;
                            tmo_cnt <= '0;
                            state   <= WAIT;
                        end else begin
                            h2f_pio32  <= head.data;
                            h2f_write  <= 1'b1;
                            issued_cnt <= issued_cnt + 16'd1;
                            state      <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    gap_cnt <= '0;
                    state   <= (GAP_CYC > 0) ? GAP : IDLE;
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST)
                        state <= IDLE;
                    else
                        gap_cnt <= gap_cnt + GW'(1);
                end
                WAIT: begin
                    if (wait_hit) begin
                        state <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TIMEOUT_W'(1);
                        if (tmo_cnt == TMO_LAST) begin
                            err_timeout <= 1'b1;
                            state       <= ERROR;
                        end
                    end
                end
                ERROR: begin
                    if (err_clear)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
